// File: rtl/tff_toggle_arbiter_pkg.sv
// Shared definitions for the toggle-flip-flop sequencer and its arbiter.
// Holds the FSM state encoding, the default sizes and a round-robin index helper.
package tff_toggle_arbiter_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TOGGLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Index after idx, wrapping at n; used to move the round-robin pointer past a winner.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tff_toggle_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Latency: zero cycles; backpressure: none, the caller decides when to take the grant.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx
);

  int  j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Sequencer sharing one T flip-flop among NREQ requesters, round-robin; t is high for cnt cycles, then done pulses.
// Latency: grant on the sampling edge, N toggle cycles, one done cycle; no backpressure, work runs to completion.
module tff_toggle_arbiter
  import tff_toggle_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] cnt,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  t,
  output logic                  q,
  output logic                  done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   widx_q;
  logic [CNT_W-1:0]   rem_q;
  logic [NREQ-1:0]    gnt_q;
  logic               q_q;

  logic [NREQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic [CNT_W-1:0]   win_cnt;
  logic               any_req;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign any_req = |req;

  always_comb begin
    win_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PTR_W'(i)) win_cnt = cnt[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    t       = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A zero count skips TOGGLE so rem never has to wrap.
        if (any_req) state_d = (win_cnt != '0) ? ST_TOGGLE : ST_DONE;
      end
      ST_TOGGLE: begin
        busy = 1'b1;
        t    = 1'b1;
        if (rem_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= '0;
      widx_q <= '0;
      rem_q  <= '0;
      gnt_q  <= '0;
      q_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q  <= arb_gnt;
            widx_q <= arb_idx;
            rem_q  <= win_cnt;
          end
        end
        ST_TOGGLE: begin
          q_q   <= ~q_q;
          rem_q <= rem_q - CNT_W'(1);
        end
        ST_DONE: begin
          gnt_q <= '0;
          ptr_q <= PTR_W'(next_idx(int'(widx_q), NREQ));
        end
        default: ;
      endcase
    end
  end

  assign gnt = gnt_q;
  assign q   = q_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Self-checking bench for tff_toggle_arbiter: vector table plus hand sequences, scoreboard popped on each done pulse.
module tb_tff_toggle_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] cnt;
  logic [3:0]  gnt;
  logic        busy, t, q, done;

  tff_toggle_arbiter #(.NREQ(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .cnt   (cnt),
    .gnt   (gnt),
    .busy  (busy),
    .t     (t),
    .q     (q),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] cnt;
    logic [3:0]  gnt;
    int          n;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    int         n;
    logic       qf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic q_exp    = 1'b0;

  int   t_cnt = 0;
  int   busy_cnt = 0;
  bit   after_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] g, input int n);
    exp_t e;
    q_exp = q_exp ^ n[0];
    e.gnt = g;
    e.n   = n;
    e.qf  = q_exp;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_sb();
    int k = 0;
    while (sb.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic start_txn(input logic [3:0] r, input logic [31:0] c, input logic [3:0] eg, input int en);
    wait_idle();
    req = r;
    cnt = c;
    push_exp(eg, en);
    @(posedge clk);
    #1;
    chk("grant", 32'(gnt), 32'(eg));
    req = '0;
    cnt = '0;
    wait_sb();
  endtask

  // Monitor: measures each transaction and compares it with the scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      t_cnt      = 0;
      busy_cnt   = 0;
      after_done = 0;
    end else begin
      if (after_done) begin
        chk("gnt_clear", 32'(gnt), 32'd0);
        chk("idle_gap", 32'(busy), 32'd0);
        after_done = 0;
      end
      if (busy) busy_cnt++;
      if (t) t_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected none, gnt=%b at %0t", gnt, $time);
        end else begin
          e = sb.pop_front();
          chk("done_gnt", 32'(gnt), 32'(e.gnt));
          chk("t_cycles", 32'(t_cnt), 32'(e.n));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.n + 1));
          chk("q_final", 32'(q), 32'(e.qf));
        end
        t_cnt      = 0;
        busy_cnt   = 0;
        after_done = 1;
      end
    end
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{req: 4'b0001, cnt: 32'h0000_0003, gnt: 4'b0001, n: 3};
    vecs[1] = '{req: 4'b0100, cnt: 32'h0000_0000, gnt: 4'b0100, n: 0};
    vecs[2] = '{req: 4'b0011, cnt: 32'h0000_0702, gnt: 4'b0001, n: 2};
    vecs[3] = '{req: 4'b1001, cnt: 32'hFF00_0001, gnt: 4'b1000, n: 255};
    vecs[4] = '{req: 4'b1010, cnt: 32'h0400_0100, gnt: 4'b0010, n: 1};
    vecs[5] = '{req: 4'b0011, cnt: 32'h0000_0506, gnt: 4'b0001, n: 6};

    // Reset asserted with all requests pending.
    reset = 1'b0;
    req   = 4'b1111;
    cnt   = '0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_t", 32'(t), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    push_exp(4'b0001, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("first_grant", 32'(gnt), 32'b0001);
    wait_sb();
    req = '0;

    for (int i = 0; i < 6; i++) begin
      start_txn(vecs[i].req, vecs[i].cnt, vecs[i].gnt, vecs[i].n);
    end

    // Restart from ptr=0, then hold all four requests for a full rotation.
    wait_idle();
    reset = 1'b0;
    q_exp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b1111;
    cnt   = 32'h0101_0101;
    push_exp(4'b0001, 1);
    push_exp(4'b0010, 1);
    push_exp(4'b0100, 1);
    push_exp(4'b1000, 1);
    push_exp(4'b0001, 1);
    wait_sb();
    req = '0;
    cnt = '0;

    // One toggle so q starts the abort case at 0.
    start_txn(4'b0010, 32'h0000_0100, 4'b0010, 1);

    // Reset in the second toggle cycle aborts immediately.
    wait_idle();
    req = 4'b0001;
    cnt = 32'h0000_0005;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_abort_q", 32'(q), 32'(q_exp ^ 1'b1));
    chk("pre_abort_t", 32'(t), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_t", 32'(t), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    q_exp = 1'b0;
    req   = 4'b0010;
    cnt   = 32'h0000_0000;
    push_exp(4'b0010, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_abort_gnt", 32'(gnt), 32'b0010);
    wait_sb();
    req = '0;

    // Request dropped and count changed mid-transaction are ignored.
    wait_idle();
    req = 4'b0010;
    cnt = 32'h0000_0400;
    push_exp(4'b0010, 4);
    @(posedge clk);
    #1;
    chk("no_abort_gnt", 32'(gnt), 32'b0010);
    req = '0;
    cnt = 32'h0000_0900;
    wait_sb();
    repeat (3) @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_q", 32'(q), 32'(q_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_toggle_arbiter.md
Name: tff_toggle_arbiter

Overview:
Shares one toggle flip-flop between NREQ requesters. Each requester asks for a number of toggles. The winner is chosen round-robin. The block then drives t high for exactly that many cycles, so q flips that many times, and reports completion with a one-cycle done pulse. It sits in front of the team's T-flip-flop cell as its sequencer. The flip-flop state register lives inside this block.

Parameters:
NREQ, 4, number of requesters (>=2)
CNT_W, 8, width of each toggle-count field

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
req  input  NREQ  request per requester, level
cnt  input  NREQ*CNT_W  toggle counts, packed; requester i at [i*CNT_W +: CNT_W]
gnt  output  NREQ  one-hot grant, registered
busy  output  1  high whenever state != IDLE
t  output  1  toggle enable applied to the flip-flop; high only in TOGGLE
q  output  1  flip-flop state, registered
done  output  1  one-cycle pulse, high only in DONE

Behaviour:
- Reset (reset=0, async, takes effect immediately, independent of clk):
  - state=IDLE; gnt=0, q=0, t=0, done=0, busy=0.
  - Round-robin pointer ptr=0; remaining count rem=0.
- States: IDLE, TOGGLE, DONE. Encoding is 2-bit binary.
- IDLE, at a clock edge with |req=1:
  - Winner w is the first set req bit searching ptr, ptr+1 … NREQ-1, 0 … ptr-1.
  - gnt<=onehot(w); rem<=cnt[w].
  - State goes to TOGGLE if cnt[w]!=0, otherwise to DONE.
- IDLE with req=0: hold all outputs.
- TOGGLE:
  - t=1 combinationally. At each edge q<=~q and rem<=rem-1.
  - When rem==1 at the edge, go to DONE.
  - Result: exactly cnt[w] consecutive t-high cycles.
- DONE:
  - done=1 for one cycle; gnt held.
  - Next edge: gnt<=0, ptr<=(w+1) mod NREQ, state<=IDLE.
- Latency: req sampled at edge k gives gnt high from k, t high cycles k..k+N-1, done in cycle k+N, back in IDLE after edge k+N+1.
  - Total busy = N+1 cycles; N=0 gives 1 cycle.
  - Minimum one IDLE cycle between transactions.
- Count and request capture:
  - cnt and req are sampled only in IDLE.
  - Changes to cnt or dropping req mid-transaction are ignored; there is no abort.
  - A requester that still holds req after DONE is re-arbitrated with ptr already past it.
- Count boundaries: CNT_W-bit unsigned; max 2^CNT_W-1 toggles. rem never wraps, since TOGGLE is never entered with rem=0.
- q keeps its value between transactions; it is not cleared by grant changes. Final q = q_start XOR (N mod 2).
- Reset mid-operation:
  - Aborts immediately: no done pulse, and q returns to 0.
  - After release, arbitration restarts from ptr=0.
- Reset release is synchronous to clk at the block boundary; that synchronizer is not part of this block.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=0, ST_TOGGLE=1, ST_DONE=2) and the default values of NREQ and CNT_W.
- One sub-module: rr_arbiter.
  - Combinational round-robin priority picker.
  - Inputs: req, ptr. Outputs: one-hot grant and binary index.
  - Reused by later shared-resource controllers.
- The FSM, counter and q register stay in tff_toggle_arbiter.

Test Plan:
1. reset=0 at time 0 with req=4'b1111 -> gnt=0, q=0, t=0, busy=0, done=0. Release reset -> first grant is 0001.
2. req=0001, cnt[0]=3 -> gnt=0001 after the edge. t high 3 cycles; q goes 0→1→0→1 and ends at 1. done pulses once; busy high 4 cycles; gnt drops after DONE.
3. req=0100, cnt[2]=0 -> gnt=0100. t never high, q unchanged, done in the next cycle, ptr=3.
4. req=1111 held, all cnt=1 -> grant sequence 0001, 0010, 0100, 1000, 0001. q toggles once per transaction; one done per grant.
5. req=0001, cnt[0]=5; assert reset=0 in the 2nd t cycle -> gnt, t and q go to 0 immediately, with no done. After release with req=0010 held, gnt=0010.
6. req=0010, cnt[1]=4; drop req and set cnt[1]=9 in the 1st t cycle -> exactly 4 t cycles, then done; final q=0 from q=0.
